conv2_window_feeder: RTL and testbench

//  Downstream neighbour of the layer-2 sampling (2x2 pooling) stage in the LeNet datapath.
//  - Captures one pooled image: 6 channels x 12x12, 32-bit pixels, raster order.
//  - Replays it to the conv-layer-2 MAC array as 5x5 windows, 6 channels in parallel.
//  - Output handshake is valid/ready.

---
 rtl/conv_pkg.sv | 42 ++++
 rtl/feature_map_ram.sv | 29 ++
 rtl/conv2_window_feeder.sv | 191 +++++++++++++++++++
 tb/tb_conv2_window_feeder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and RAM word layout for the conv-2 window feeder.
// CONV2_SAME_PAD_EN selects 'same' (zero-padded) windows instead of 'valid' windows.
package conv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CH     = 6;
    localparam int unsigned IMG_W  = 12;
    localparam int unsigned IMG_H  = 12;
    localparam int unsigned K      = 5;
    localparam int unsigned PIX_N  = IMG_W * IMG_H;
    localparam int unsigned ADDR_W = $clog2(PIX_N);
    localparam int unsigned TAP_W  = $clog2(K * K);
    localparam int unsigned CNT_W  = $clog2(IMG_W + 1);
    localparam int unsigned KC_W   = $clog2(K);
    localparam int unsigned POS_W  = CNT_W + 1;

`ifdef CONV2_SAME_PAD_EN
    localparam int unsigned PAD   = (K - 1) / 2;
    localparam int unsigned OUT_W = IMG_W;
    localparam int unsigned OUT_H = IMG_H;
`else
    localparam int unsigned OUT_W = IMG_W - K + 1;
    localparam int unsigned OUT_H = IMG_H - K + 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // One RAM word holds all channels of a pixel; ch[0] is channel 1.
    typedef struct packed {
        logic [CH-1:0][DATA_W-1:0] ch;
    } ram_word_t;

    function automatic logic [TAP_W-1:0] tap_index(input logic [KC_W-1:0] ky,
                                                   input logic [KC_W-1:0] kx);
        return TAP_W'(ky) * TAP_W'(K) + TAP_W'(kx);
    endfunction

endpackage

// File: rtl/feature_map_ram.sv
// Single-image feature-map store: one write port, one registered read port.
// Read data holds its value whenever no read is requested.
module feature_map_ram
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  ram_word_t         i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output ram_word_t         o_rdata
);

    ram_word_t r_mem [PIX_N];
    ram_word_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/conv2_window_feeder.sv
// Captures one pooled 6x12x12 image and replays it as 5x5 windows over valid/ready.
// CONV2_SAME_PAD_EN switches to zero-padded 'same' windows (12x12 window positions).
module conv2_window_feeder
    import conv_pkg::*;
(
    input  logic              Clock,
    input  logic              Input_Reset,
    input  logic              Input_Valid,
    input  logic              Input_Finish,
    input  logic [DATA_W-1:0] Input_Pixel_1,
    input  logic [DATA_W-1:0] Input_Pixel_2,
    input  logic [DATA_W-1:0] Input_Pixel_3,
    input  logic [DATA_W-1:0] Input_Pixel_4,
    input  logic [DATA_W-1:0] Input_Pixel_5,
    input  logic [DATA_W-1:0] Input_Pixel_6,
    input  logic              Output_Ready,
    output logic [DATA_W-1:0] Output_Pixel_1,
    output logic [DATA_W-1:0] Output_Pixel_2,
    output logic [DATA_W-1:0] Output_Pixel_3,
    output logic [DATA_W-1:0] Output_Pixel_4,
    output logic [DATA_W-1:0] Output_Pixel_5,
    output logic [DATA_W-1:0] Output_Pixel_6,
    output logic [TAP_W-1:0]  Output_Tap,
    output logic              Output_Last_Tap,
    output logic              Output_Valid,
    output logic              Output_Finish,
    output logic              Output_Error
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [CNT_W-1:0]  r_oy, r_ox;
    logic [KC_W-1:0]   r_ky, r_kx;
    logic              r_issue_done;
    logic              r_s1_vld, r_s1_last, r_s1_fin, r_s1_zero;
    logic [TAP_W-1:0]  r_s1_tap, r_out_tap;
    ram_word_t         r_out_data;
    logic              r_out_vld, r_out_last, r_out_fin, r_err;

    ram_word_t         w_wdata, w_rdata;
    logic              w_we, w_re, w_xfer, w_out_free, w_issue, w_inb;
    logic              w_last_k, w_last_win;
    logic [POS_W-1:0]  w_row, w_col;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_wdata.ch = {Input_Pixel_6, Input_Pixel_5, Input_Pixel_4,
                         Input_Pixel_3, Input_Pixel_2, Input_Pixel_1};
    assign w_we       = Input_Valid && (r_state != ST_STREAM);
    assign w_out_free = !r_out_vld || Output_Ready;
    assign w_xfer     = r_out_vld && Output_Ready;
    // A new read is issued whenever the stage-1 slot is empty or drains this cycle.
    assign w_issue    = (r_state == ST_STREAM) && !r_issue_done && (!r_s1_vld || w_out_free);

`ifdef CONV2_SAME_PAD_EN
    logic [POS_W-1:0] w_row_p, w_col_p;
    assign w_row_p = POS_W'(r_oy) + POS_W'(r_ky);
    assign w_col_p = POS_W'(r_ox) + POS_W'(r_kx);
    assign w_inb   = (w_row_p >= POS_W'(PAD)) && (w_row_p < POS_W'(IMG_H + PAD)) &&
                     (w_col_p >= POS_W'(PAD)) && (w_col_p < POS_W'(IMG_W + PAD));
    assign w_row   = w_row_p - POS_W'(PAD);
    assign w_col   = w_col_p - POS_W'(PAD);
`else
    assign w_inb   = 1'b1;
    assign w_row   = POS_W'(r_oy) + POS_W'(r_ky);
    assign w_col   = POS_W'(r_ox) + POS_W'(r_kx);
`endif

    assign w_rd_addr  = ADDR_W'(w_row) * ADDR_W'(IMG_W) + ADDR_W'(w_col);
    assign w_re       = w_issue && w_inb;
    assign w_last_k   = (r_kx == KC_W'(K - 1)) && (r_ky == KC_W'(K - 1));
    assign w_last_win = (r_ox == CNT_W'(OUT_W - 1)) && (r_oy == CNT_W'(OUT_H - 1));

    feature_map_ram u_ram (
        .clk     (Clock),
        .i_we    (w_we),
        .i_waddr (r_wr_addr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clock) begin
        if (Input_Reset) begin
            r_state      <= ST_IDLE;
            r_wr_addr    <= '0;
            r_oy         <= '0;
            r_ox         <= '0;
            r_ky         <= '0;
            r_kx         <= '0;
            r_issue_done <= 1'b0;
            r_s1_vld     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_fin     <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_tap     <= '0;
            r_out_tap    <= '0;
            r_out_data   <= '0;
            r_out_vld    <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_fin    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FILL: begin
                    if (Input_Valid) begin
                        if (r_wr_addr == ADDR_W'(PIX_N - 1)) begin
                            r_state   <= ST_STREAM;
                            r_wr_addr <= '0;
                        end else begin
                            r_state   <= ST_FILL;
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        end
                    end else if ((r_state == ST_FILL) && Input_Finish) begin
                        r_err     <= 1'b1;
                        r_wr_addr <= '0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (Input_Valid) begin
                        r_err <= 1'b1;
                    end
                    if (w_xfer && r_out_fin) begin
                        r_state      <= ST_IDLE;
                        r_issue_done <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Window counters: kx fastest, then ky, ox, oy; wrap to 0 after the last tap.
            if (w_issue) begin
                r_s1_tap  <= tap_index(r_ky, r_kx);
                r_s1_last <= w_last_k;
                r_s1_fin  <= w_last_k && w_last_win;
                r_s1_zero <= !w_inb;
                if (r_kx == KC_W'(K - 1)) begin
                    r_kx <= '0;
                    if (r_ky == KC_W'(K - 1)) begin
                        r_ky <= '0;
                        if (r_ox == CNT_W'(OUT_W - 1)) begin
                            r_ox <= '0;
                            if (r_oy == CNT_W'(OUT_H - 1)) begin
                                r_oy         <= '0;
                                r_issue_done <= 1'b1;
                            end else begin
                                r_oy <= r_oy + CNT_W'(1);
                            end
                        end else begin
                            r_ox <= r_ox + CNT_W'(1);
                        end
                    end else begin
                        r_ky <= r_ky + KC_W'(1);
                    end
                end else begin
                    r_kx <= r_kx + KC_W'(1);
                end
            end

            if (w_issue) begin
                r_s1_vld <= 1'b1;
            end else if (w_out_free) begin
                r_s1_vld <= 1'b0;
            end

            if (w_out_free) begin
                r_out_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_out_data <= r_s1_zero ? '0 : w_rdata;
                    r_out_tap  <= r_s1_tap;
                    r_out_last <= r_s1_last;
                    r_out_fin  <= r_s1_fin;
                end
            end
        end
    end

    assign Output_Pixel_1  = r_out_data.ch[0];
    assign Output_Pixel_2  = r_out_data.ch[1];
    assign Output_Pixel_3  = r_out_data.ch[2];
    assign Output_Pixel_4  = r_out_data.ch[3];
    assign Output_Pixel_5  = r_out_data.ch[4];
    assign Output_Pixel_6  = r_out_data.ch[5];
    assign Output_Tap      = r_out_tap;
    assign Output_Last_Tap = r_out_last;
    assign Output_Valid    = r_out_vld;
    assign Output_Finish   = r_out_fin;
    assign Output_Error    = r_err;

endmodule

// File: tb/tb_conv2_window_feeder.sv
// Self-checking bench for conv2_window_feeder against a window-enumeration reference model.
// Honours CONV2_SAME_PAD_EN so the same bench covers both window modes.
module tb_conv2_window_feeder;

    localparam int IW    = 12;
    localparam int IH    = 12;
    localparam int KK    = 5;
    localparam int NPIX  = IW * IH;
    localparam int MAXB  = 3600;
`ifdef CONV2_SAME_PAD_EN
    localparam int PADB  = 2;
    localparam int ON    = 12;
`else
    localparam int PADB  = 0;
    localparam int ON    = 8;
`endif

    logic        Clock;
    logic        Input_Reset, Input_Valid, Input_Finish, Output_Ready;
    logic [31:0] ip [6];
    logic [31:0] op [6];
    logic [4:0]  Output_Tap;
    logic        Output_Last_Tap, Output_Valid, Output_Finish, Output_Error;

    int errors = 0;
    int checks = 0;

    logic [31:0] img [6][NPIX];
    logic [31:0] exp_pix [MAXB][6];
    int          exp_tap [MAXB];
    bit          exp_last [MAXB];
    bit          exp_fin [MAXB];
    int          nexp;
    logic [31:0] got_pix [MAXB][6];
    int          got_tap [MAXB];
    bit          got_last [MAXB];
    bit          got_fin [MAXB];
    int          ngot;
    int          stall_bad;
    bit          timed_out;

    conv2_window_feeder dut (
        .Clock           (Clock),
        .Input_Reset     (Input_Reset),
        .Input_Valid     (Input_Valid),
        .Input_Finish    (Input_Finish),
        .Input_Pixel_1   (ip[0]),
        .Input_Pixel_2   (ip[1]),
        .Input_Pixel_3   (ip[2]),
        .Input_Pixel_4   (ip[3]),
        .Input_Pixel_5   (ip[4]),
        .Input_Pixel_6   (ip[5]),
        .Output_Ready    (Output_Ready),
        .Output_Pixel_1  (op[0]),
        .Output_Pixel_2  (op[1]),
        .Output_Pixel_3  (op[2]),
        .Output_Pixel_4  (op[3]),
        .Output_Pixel_5  (op[4]),
        .Output_Pixel_6  (op[5]),
        .Output_Tap      (Output_Tap),
        .Output_Last_Tap (Output_Last_Tap),
        .Output_Valid    (Output_Valid),
        .Output_Finish   (Output_Finish),
        .Output_Error    (Output_Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Ramp image (ch<<16 | index, ch counted from 1) or random pixels.
    task automatic load_image(input bit random_pix);
        for (int ch = 0; ch < 6; ch++)
            for (int idx = 0; idx < NPIX; idx++)
                img[ch][idx] = random_pix ? $urandom : 32'(((ch + 1) << 16) | idx);
    endtask

    // Enumerate every window position and tap of the image in raster order.
    task automatic build_expected();
        int r, c;
        nexp = 0;
        for (int oy = 0; oy < ON; oy++)
            for (int ox = 0; ox < ON; ox++)
                for (int ky = 0; ky < KK; ky++)
                    for (int kx = 0; kx < KK; kx++) begin
                        r = oy + ky - PADB;
                        c = ox + kx - PADB;
                        for (int ch = 0; ch < 6; ch++)
                            exp_pix[nexp][ch] = (r < 0 || r >= IH || c < 0 || c >= IW) ?
                                                32'd0 : img[ch][r * IW + c];
                        exp_tap[nexp]  = ky * KK + kx;
                        exp_last[nexp] = (ky == KK - 1) && (kx == KK - 1);
                        exp_fin[nexp]  = exp_last[nexp] && (oy == ON - 1) && (ox == ON - 1);
                        nexp++;
                    end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < nexp; i++) begin
            for (int ch = 0; ch < 6; ch++)
                if (got_pix[i][ch] !== exp_pix[i][ch]) return i;
            if (got_tap[i] != exp_tap[i] || got_last[i] != exp_last[i] || got_fin[i] != exp_fin[i])
                return i;
        end
        return -1;
    endfunction

    task automatic fill(input int nbeats, input bit gaps);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                repeat ($urandom_range(2)) begin
                    @(negedge Clock);
                    Input_Valid = 1'b0;
                end
            end
            @(negedge Clock);
            Input_Valid = 1'b1;
            for (int ch = 0; ch < 6; ch++) ip[ch] = img[ch][b];
        end
    endtask

    // Drive Ready, record transferred beats, and count any stall where outputs moved.
    task automatic collect(input int ready_pct, input int pulse_pct, input int stop_at);
        bit          rdy, prev_stall;
        logic [31:0] prev_pix [6];
        logic [4:0]  prev_tap;
        bit          prev_last, prev_fin;
        bit          moved;
        ngot = 0; stall_bad = 0; timed_out = 1'b1; prev_stall = 1'b0;
        prev_tap = '0; prev_last = 1'b0; prev_fin = 1'b0;
        for (int ch = 0; ch < 6; ch++) prev_pix[ch] = '0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge Clock);
            if (prev_stall) begin
                moved = (Output_Valid !== 1'b1) || (Output_Tap !== prev_tap) ||
                        (Output_Last_Tap !== prev_last) || (Output_Finish !== prev_fin);
                for (int ch = 0; ch < 6; ch++) if (op[ch] !== prev_pix[ch]) moved = 1'b1;
                if (moved) stall_bad++;
            end
            rdy = ($urandom_range(99) < ready_pct);
            Output_Ready = rdy;
            Input_Valid = (pulse_pct > 0) && ($urandom_range(99) < pulse_pct);
            for (int ch = 0; ch < 6; ch++) ip[ch] = $urandom;
            if (Output_Valid === 1'b1 && rdy) begin
                for (int ch = 0; ch < 6; ch++) got_pix[ngot][ch] = op[ch];
                got_tap[ngot]  = int'(Output_Tap);
                got_last[ngot] = Output_Last_Tap;
                got_fin[ngot]  = Output_Finish;
                ngot++;
                if (Output_Finish === 1'b1 || ngot == stop_at || ngot == MAXB) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            prev_stall = (Output_Valid === 1'b1) && !rdy;
            for (int ch = 0; ch < 6; ch++) prev_pix[ch] = op[ch];
            prev_tap = Output_Tap; prev_last = Output_Last_Tap; prev_fin = Output_Finish;
        end
        Input_Valid = 1'b0;
    endtask

    task automatic test_reset();
        Input_Reset = 1'b1; Input_Valid = 1'b0; Input_Finish = 1'b0; Output_Ready = 1'b1;
        for (int ch = 0; ch < 6; ch++) ip[ch] = '0;
        repeat (3) @(negedge Clock);
        checks++;
        if (Output_Valid !== 1'b0 || Output_Finish !== 1'b0 || Output_Last_Tap !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b finish=%b last=%b, required 0/0/0",
                     Output_Valid, Output_Finish, Output_Last_Tap);
        end
        checks++;
        if (Output_Error !== 1'b0 || Output_Tap !== 5'd0) begin
            errors++;
            $display("FAIL reset_err_tap: error=%b tap=%0d, required 0/0", Output_Error, Output_Tap);
        end
        checks++;
        if ({op[0], op[1], op[2], op[3], op[4], op[5]} !== 192'd0) begin
            errors++;
            $display("FAIL reset_pixels: P1=%h P6=%h, required 0", op[0], op[5]);
        end
        Input_Reset = 1'b0;
    endtask

    task automatic test_ramp();
        int d;
        load_image(1'b0);
        build_expected();
        fill(NPIX, 1'b0);
        collect(100, 0, 0);
        checks++;
        if (timed_out || ngot != nexp) begin
            errors++;
            $display("FAIL ramp_count: beats=%0d timeout=%0d, required %0d", ngot, timed_out, nexp);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL ramp_data: beat %0d P1=%h tap=%0d, required P1=%h tap=%0d",
                     d + 1, got_pix[d][0], got_tap[d], exp_pix[d][0], exp_tap[d]);
        end
`ifdef CONV2_SAME_PAD_EN
        checks++;
        if ({got_pix[0][0], got_pix[0][1], got_pix[0][2], got_pix[0][3], got_pix[0][4],
             got_pix[0][5]} !== 192'd0 || got_tap[0] != 0) begin
            errors++;
            $display("FAIL pad_beat1: P1=%h tap=%0d, required all 0 tap 0", got_pix[0][0], got_tap[0]);
        end
        checks++;
        if (got_pix[12][0] !== 32'h00010000 || got_tap[12] != 12) begin
            errors++;
            $display("FAIL pad_beat13: P1=%h tap=%0d, required 00010000 tap 12",
                     got_pix[12][0], got_tap[12]);
        end
        checks++;
        if (ngot != 3600 || !got_fin[3599] || got_fin[3598]) begin
            errors++;
            $display("FAIL pad_finish: beats=%0d, required 3600 with Finish on last", ngot);
        end
`else
        checks++;
        if (got_pix[0][0] !== 32'h00010000 || got_tap[0] != 0 || got_pix[1][0] !== 32'h00010001) begin
            errors++;
            $display("FAIL ramp_beat1_2: P1=%h,%h tap=%0d, required 00010000,00010001 tap 0",
                     got_pix[0][0], got_pix[1][0], got_tap[0]);
        end
        checks++;
        if (got_pix[24][0] !== 32'h00010034 || !got_last[24] || got_last[23]) begin
            errors++;
            $display("FAIL ramp_beat25: P1=%h last=%0d, required 00010034 last 1",
                     got_pix[24][0], got_last[24]);
        end
        checks++;
        if (got_pix[1599][5] !== 32'h0006008F || !got_fin[1599] || got_fin[1598]) begin
            errors++;
            $display("FAIL ramp_beat1600: P6=%h finish=%0d, required 0006008F finish 1",
                     got_pix[1599][5], got_fin[1599]);
        end
`endif
        @(negedge Clock);
        checks++;
        if (Output_Valid !== 1'b0 || Output_Error !== 1'b0) begin
            errors++;
            $display("FAIL ramp_after: valid=%b error=%b, required 0/0", Output_Valid, Output_Error);
        end
    endtask

    task automatic test_random_ready();
        int d;
        load_image(1'b1);
        build_expected();
        fill(NPIX, 1'b1);
        collect(50, 0, 0);
        checks++;
        if (timed_out || ngot != nexp) begin
            errors++;
            $display("FAIL rready_count: beats=%0d timeout=%0d, required %0d", ngot, timed_out, nexp);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL rready_data: beat %0d P1=%h, required %h", d + 1, got_pix[d][0], exp_pix[d][0]);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL rready_stall: %0d stalls with moving outputs, required 0", stall_bad);
        end
    endtask

    task automatic test_early_finish();
        int vseen, d;
        load_image(1'b1);
        fill(100, 1'b1);
        @(negedge Clock);
        Input_Valid = 1'b0; Input_Finish = 1'b1;
        @(negedge Clock);
        Input_Finish = 1'b0;
        checks++;
        if (Output_Error !== 1'b1) begin
            errors++;
            $display("FAIL early_error: error=%b, required 1", Output_Error);
        end
        vseen = 0;
        repeat (40) begin
            @(negedge Clock);
            if (Output_Valid !== 1'b0) vseen++;
        end
        checks++;
        if (vseen != 0) begin
            errors++;
            $display("FAIL early_novalid: %0d valid cycles, required 0", vseen);
        end
        load_image(1'b1);
        build_expected();
        fill(NPIX, 1'b0);
        collect(100, 0, 0);
        d = first_diff();
        checks++;
        if (timed_out || ngot != nexp || d != -1) begin
            errors++;
            $display("FAIL early_refill: beats=%0d first_bad=%0d, required %0d and -1", ngot, d, nexp);
        end
        checks++;
        if (Output_Error !== 1'b1) begin
            errors++;
            $display("FAIL early_sticky: error=%b, required 1", Output_Error);
        end
    endtask

    task automatic test_reset_mid_stream();
        int d;
        load_image(1'b0);
        build_expected();
        fill(NPIX, 1'b0);
        collect(100, 0, 700);
        checks++;
        if (timed_out || ngot != 700) begin
            errors++;
            $display("FAIL midrst_reach: beats=%0d, required 700", ngot);
        end
        Input_Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if (Output_Valid !== 1'b0 || Output_Finish !== 1'b0 || Output_Last_Tap !== 1'b0 ||
            Output_Error !== 1'b0 || Output_Tap !== 5'd0 ||
            {op[0], op[1], op[2], op[3], op[4], op[5]} !== 192'd0) begin
            errors++;
            $display("FAIL midrst_zero: valid=%b err=%b tap=%0d P1=%h, required all 0",
                     Output_Valid, Output_Error, Output_Tap, op[0]);
        end
        Input_Reset = 1'b0;
        fill(NPIX, 1'b0);
        collect(100, 0, 0);
        d = first_diff();
        checks++;
        if (timed_out || ngot != nexp || d != -1) begin
            errors++;
            $display("FAIL midrst_restart: beats=%0d first_bad=%0d tap0=%0d, required %0d, -1, 0",
                     ngot, d, got_tap[0], nexp);
        end
    endtask

    task automatic test_valid_in_stream();
        int d;
        load_image(1'b0);
        build_expected();
        @(negedge Clock);
        checks++;
        if (Output_Error !== 1'b0) begin
            errors++;
            $display("FAIL vstream_pre: error=%b, required 0", Output_Error);
        end
        fill(NPIX, 1'b0);
        collect(100, 30, 0);
        d = first_diff();
        checks++;
        if (timed_out || ngot != nexp || d != -1) begin
            errors++;
            $display("FAIL vstream_data: beats=%0d first_bad=%0d, required %0d and -1", ngot, d, nexp);
        end
        @(negedge Clock);
        checks++;
        if (Output_Error !== 1'b1) begin
            errors++;
            $display("FAIL vstream_error: error=%b, required 1", Output_Error);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_random_ready();
        test_early_finish();
        test_reset_mid_stream();
        test_valid_in_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
